// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and halt sequencing (RUN -> DRAIN -> HALTED).
// Optional PERF_CNT_EN macro adds saturating stall/flush performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INST     = 32'h0000_0000,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nWrite_PC,
    input  logic        nWrite_IF_ID,
    input  logic        flush_IF_ID,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic        halt_ID,
    input  logic [31:0] inst_mem,
    output logic [31:0] pc_IF,
    output logic [31:0] inst_ID,
    output logic [31:0] pc4_ID,
    output logic        valid_ID,
    output logic        halted
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_d, inst_d, pc4_d, pc_plus4;
    logic              valid_d, halted_d;
    logic [CNT_W-1:0]  drain_q, drain_d;
    logic              halt_accept;

    assign pc_plus4    = pc_IF + XLEN'(4);
    assign halt_accept = halt_ID && valid_ID && !nWrite_IF_ID;

    // State and pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            pc_IF    <= RESET_PC;
            inst_ID  <= NOP_INST;
            pc4_ID   <= '0;
            valid_ID <= 1'b0;
            halted   <= 1'b0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_IF    <= pc_d;
            inst_ID  <= inst_d;
            pc4_ID   <= pc4_d;
            valid_ID <= valid_d;
            halted   <= halted_d;
            drain_q  <= drain_d;
        end
    end

    // Next-state: halt acceptance outranks redirect and flush
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_IF;
        inst_d   = inst_ID;
        pc4_d    = pc4_ID;
        valid_d  = valid_ID;
        halted_d = halted;
        drain_d  = drain_q;
        case (state_q)
            RUN: begin
                if (halt_accept) begin
                    state_d = DRAIN;
                    inst_d  = NOP_INST;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b0;
                    drain_d = DRAIN_INIT;
                end else begin
                    if (!nWrite_PC) begin
                        case (pc_sel)
                            2'b01:   pc_d = branch_target;
                            2'b10:   pc_d = jump_target;
                            default: pc_d = pc_plus4;
                        endcase
                    end
                    if (!nWrite_IF_ID) begin
                        pc4_d = pc_plus4;
                        if (flush_IF_ID) begin
                            inst_d  = NOP_INST;
                            valid_d = 1'b0;
                        end else begin
                            inst_d  = inst_mem;
                            valid_d = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else begin
                    drain_d = drain_q - CNT_W'(1);
                end
            end
            HALTED:  halted_d = 1'b1;
            default: state_d  = RUN;
        endcase
    end

`ifdef PERF_CNT_EN
    // Saturating performance counters, active only while fetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (state_q == RUN) begin
            if (nWrite_PC && (stall_cnt != '1))
                stall_cnt <= stall_cnt + XLEN'(1);
            if (flush_IF_ID && !nWrite_IF_ID && (flush_cnt != '1))
                flush_cnt <= flush_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam int          DRAIN    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nWrite_PC = 1'b0, nWrite_IF_ID = 1'b0, flush_IF_ID = 1'b0, halt_ID = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic [31:0] branch_target = '0, jump_target = '0, inst_mem;
    logic [31:0] pc_IF, inst_ID, pc4_ID;
    logic        valid_ID, halted;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST), .DRAIN_CYCLES(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .nWrite_PC(nWrite_PC), .nWrite_IF_ID(nWrite_IF_ID), .flush_IF_ID(flush_IF_ID),
        .pc_sel(pc_sel), .branch_target(branch_target), .jump_target(jump_target),
        .halt_ID(halt_ID), .inst_mem(inst_mem),
        .pc_IF(pc_IF), .inst_ID(inst_ID), .pc4_ID(pc4_ID), .valid_ID(valid_ID), .halted(halted)
`ifdef PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: a fixed function of the fetch address
    assign inst_mem = pattern(pc_IF);

    int n_asserts = 0;
    int n_fail    = 0;
    int edge_no   = 0;
    int acc_edge  = 0;

    logic [31:0] m_pc, m_inst, m_pc4, m_stall, m_flush;
    logic        m_valid, m_halted, m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_inst = NOP_INST; m_pc4 = '0; m_valid = 1'b0;
        m_halted = 1'b0; m_acc = 1'b0; m_stall = '0; m_flush = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc_IF, m_pc);
        chk({tag, ".inst"}, inst_ID, m_inst);
        chk({tag, ".valid"}, {31'd0, valid_ID}, {31'd0, m_valid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
        if (!m_acc) chk({tag, ".pc4"}, pc4_ID, m_pc4);
`ifdef PERF_CNT_EN
        chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
        chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
`endif
    endtask

    // Drive one cycle of inputs, advance the model, clock, and compare
    task automatic step(input string tag, input logic nwpc, input logic nwif, input logic fl,
                        input logic [1:0] sel, input logic [31:0] bt, input logic [31:0] jt,
                        input logic hlt);
        logic [31:0] npc;
        nWrite_PC = nwpc; nWrite_IF_ID = nwif; flush_IF_ID = fl;
        pc_sel = sel; branch_target = bt; jump_target = jt; halt_ID = hlt;
        if (!m_acc) begin
            if (nwpc && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (fl && !nwif && m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
            if (hlt && m_valid && !nwif) begin
                m_acc = 1'b1; acc_edge = edge_no + 1;
                m_inst = NOP_INST; m_valid = 1'b0;
            end else begin
                npc = nwpc ? m_pc : (sel == 2'b01) ? bt : (sel == 2'b10) ? jt : m_pc + 32'd4;
                if (!nwif) begin
                    m_pc4 = m_pc + 32'd4;
                    m_inst = fl ? NOP_INST : pattern(m_pc);
                    m_valid = !fl;
                end
                m_pc = npc;
            end
        end
        m_halted = m_acc && (edge_no + 1 >= acc_edge + DRAIN);
        @(posedge clk);
        #1;
        edge_no++;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rnd_step(input string tag, input int halt_odds);
        logic [31:0] r;
        r = $urandom;
        step(tag, r[0] & r[1], r[2] & r[3], r[4], r[6:5], $urandom & 32'hFFFF_FFFC,
             $urandom & 32'hFFFF_FFFC, ($urandom_range(halt_odds - 1) == 0));
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        check_all("reset");
        chk("reset.pc_const", pc_IF, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // Free run
        for (int i = 0; i < 3; i++) idle("run");
        chk("run3.pc", pc_IF, 32'd12);
        chk("run3.inst", inst_ID, pattern(32'd8));
        chk("run3.pc4", pc4_ID, 32'd12);
        chk("run3.valid", {31'd0, valid_ID}, 32'd1);

        // Load-use stall at 0x10
        idle("to10");
        chk("stall.pre_pc", pc_IF, 32'h10);
        for (int i = 0; i < 2; i++) begin
            step("stall", 1'b1, 1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
            chk("stall.pc_hold", pc_IF, 32'h10);
            chk("stall.inst_hold", inst_ID, pattern(32'hC));
        end
        idle("resume");
        chk("resume.pc", pc_IF, 32'h14);

        // Taken branch with flush at 0x20
        for (int i = 0; i < 3; i++) idle("to20");
        chk("beq.pre_pc", pc_IF, 32'h20);
        step("beq", 1'b0, 1'b0, 1'b1, 2'b01, 32'h40, 32'h0, 1'b0);
        chk("beq.pc", pc_IF, 32'h40);
        chk("beq.inst", inst_ID, NOP_INST);
        chk("beq.valid", {31'd0, valid_ID}, 32'd0);

        // Stall and flush together: hold wins, jump is re-evaluated next cycle
        idle("prejump");
        step("stjmp", 1'b1, 1'b1, 1'b1, 2'b10, 32'h0, 32'h80, 1'b0);
        chk("stjmp.pc", pc_IF, 32'h44);
        chk("stjmp.valid", {31'd0, valid_ID}, 32'd1);
        step("jump", 1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h80, 1'b0);
        chk("jump.pc", pc_IF, 32'h80);

        // Randomized traffic, no halts
        for (int i = 0; i < 150; i++) rnd_step("rnd", 1 << 30);

        // Halt with random inputs alongside and after acceptance
        async_reset("rst2");
        idle("prehalt");
        step("halt", 1'b0, 1'b0, 1'b1, 2'b10, 32'h0, 32'h800, 1'b1);
        chk("halt.pc_frozen", pc_IF, 32'h4);
        chk("halt.valid", {31'd0, valid_ID}, 32'd0);
        for (int i = 0; i < DRAIN - 1; i++) rnd_step("drain", 2);
        chk("drain.not_halted", {31'd0, halted}, 32'd0);
        rnd_step("halted_edge", 2);
        chk("halted.rise", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 12; i++) rnd_step("halted", 2);
        chk("halted.pc_frozen", pc_IF, 32'h4);

        // Reset one cycle into the drain
        async_reset("rst3");
        idle("prehalt2");
        step("halt2", 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
        rnd_step("drain2", 2);
        async_reset("rst_mid_drain");
        chk("rst_mid_drain.pc", pc_IF, RESET_PC);
        for (int i = 0; i < 6; i++) idle("post_rst");
        chk("post_rst.halted", {31'd0, halted}, 32'd0);

        // PC adder wrap
        step("to_top", 1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFC, 32'h0, 1'b0);
        idle("wrap");
        chk("wrap.pc", pc_IF, 32'h0);
        chk("wrap.pc4", pc4_ID, 32'h0);

        // Randomized traffic with occasional halts and periodic resets
        for (int i = 0; i < 300; i++) begin
            if (i % 40 == 39) async_reset("rnd_rst");
            else rnd_step("rndh", 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
